// File: rtl/etm_mul_seq.sv
// Sequential error-tolerant multiplier: the upper halves go through an iterative shift-add engine,
// the lower halves through a one-shot Mitchell log approximation. Exact paths cover mode=1 and small operands.
module etm_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 approx
);

  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int KW = $clog2(H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r, state_s;

  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      cnt_r;
  logic [CW-1:0]      n_r;
  logic               etm_r;
  logic [H-1:0]       alo_r;
  logic [H-1:0]       blo_r;
  logic [WIDTH-1:0]   mit_r;
  logic [2*WIDTH-1:0] p_r;
  logic               approx_r;
  logic               out_valid_r;

  logic               accept_s;
  logic               last_s;
  logic [2*WIDTH-1:0] acc_s;
  logic [WIDTH-1:0]   mit_s;

  function automatic logic [KW-1:0] msb_idx(input logic [H-1:0] x);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < H; i++) begin
      k = x[i] ? KW'(i) : k;
    end
    return k;
  endfunction

  // Mitchell: x*y ~ 2^(k1+k2) * (1 + f1/2^k1 + f2/2^k2), with the characteristic carry folded in when S >= T
  function automatic logic [WIDTH-1:0] mitchell(input logic [H-1:0] x, input logic [H-1:0] y);
    logic [KW-1:0] k1, k2;
    logic [KW:0]   ksum;
    logic [WIDTH:0] f1, f2, s, t, r;
    k1   = msb_idx(x);
    k2   = msb_idx(y);
    ksum = {1'b0, k1} + {1'b0, k2};
    f1   = (WIDTH+1)'(x) - ((WIDTH+1)'(1'b1) << k1);
    f2   = (WIDTH+1)'(y) - ((WIDTH+1)'(1'b1) << k2);
    s    = (f1 << k2) + (f2 << k1);
    t    = (WIDTH+1)'(1'b1) << ksum;
    if (x == '0 || y == '0) begin
      r = '0;
    end else if (s < t) begin
      r = t + s;
    end else begin
      r = s << 1;
    end
    return r[WIDTH-1:0];
  endfunction

  assign in_ready  = (state_r == IDLE) && rst_n;
  assign accept_s  = in_valid && in_ready;
  assign last_s    = (cnt_r == n_r - CW'(1));
  assign acc_s     = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
  assign mit_s     = (cnt_r == '0) ? mitchell(alo_r, blo_r) : mit_r;
  assign out_valid = out_valid_r;
  assign p         = p_r;
  assign approx    = approx_r;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = CALC;
        else          state_s = IDLE;
      end
      CALC: begin
        if (last_s) state_s = DONE;
        else        state_s = CALC;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, shift-add iteration and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_r     <= '0;
      mplier_r    <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      n_r         <= '0;
      etm_r       <= 1'b0;
      alo_r       <= '0;
      blo_r       <= '0;
      mit_r       <= '0;
      p_r         <= '0;
      approx_r    <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            acc_r <= '0;
            cnt_r <= '0;
            alo_r <= a[H-1:0];
            blo_r <= b[H-1:0];
            if (mode) begin
              mplier_r <= a;
              mcand_r  <= {{WIDTH{1'b0}}, b};
              n_r      <= CW'(WIDTH);
              etm_r    <= 1'b0;
            end else if (a[WIDTH-1:H] == '0) begin
              mplier_r <= a;
              mcand_r  <= {{WIDTH{1'b0}}, b};
              n_r      <= CW'(H);
              etm_r    <= 1'b0;
            end else if (b[WIDTH-1:H] == '0) begin
              mplier_r <= b;
              mcand_r  <= {{WIDTH{1'b0}}, a};
              n_r      <= CW'(H);
              etm_r    <= 1'b0;
            end else begin
              mplier_r <= {{H{1'b0}}, a[WIDTH-1:H]};
              mcand_r  <= {{(2*WIDTH-H){1'b0}}, b[WIDTH-1:H]};
              n_r      <= CW'(H);
              etm_r    <= 1'b1;
            end
          end
        end
        CALC: begin
          acc_r    <= acc_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          mit_r    <= mit_s;
          if (last_s) begin
            // ETM keeps only the upper-half product in the top WIDTH bits; it cannot exceed WIDTH bits
            p_r         <= etm_r ? {acc_s[WIDTH-1:0], mit_s} : acc_s;
            approx_r    <= etm_r;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_etm_mul_seq.sv
// Self-checking bench for etm_mul_seq: directed vectors, backpressure, mid-op reset and randomized
// transactions against an arithmetic reference model.
module tb_etm_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic        approx;

  int n_checks = 0;
  int n_errors = 0;

  etm_mul_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p),
    .approx   (approx)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int msb_of(input int unsigned x);
    int k = 0;
    for (int i = 0; i < 16; i++) if ((x >> i) != 0) k = i;
    return k;
  endfunction

  function automatic int unsigned ref_mitchell(input int unsigned x, input int unsigned y);
    int k1, k2;
    int unsigned f1, f2, s, t;
    if (x == 0 || y == 0) return 0;
    k1 = msb_of(x);
    k2 = msb_of(y);
    f1 = x - (2 ** k1);
    f2 = y - (2 ** k2);
    s  = f1 * (2 ** k2) + f2 * (2 ** k1);
    t  = 2 ** (k1 + k2);
    return (s < t) ? (t + s) : (2 * s);
  endfunction

  task automatic ref_model(input logic [15:0] ra, input logic [15:0] rb, input logic rmode,
                           output logic [31:0] rp, output logic rapprox, output int rn);
    int unsigned ua, ub;
    ua = ra;
    ub = rb;
    if (rmode) begin
      rp = 32'(ua * ub); rapprox = 1'b0; rn = 16;
    end else if ((ua / 256) == 0 || (ub / 256) == 0) begin
      rp = 32'(ua * ub); rapprox = 1'b0; rn = 8;
    end else begin
      rp = 32'((ua / 256) * (ub / 256) * 65536 + ref_mitchell(ua % 256, ub % 256));
      rapprox = 1'b1; rn = 8;
    end
  endtask

  // One full transaction; hold = cycles out_ready stays low after out_valid, pulse = request new work meanwhile
  task automatic run_txn(input string tag, input logic [15:0] ta, input logic [15:0] tb_, input logic tm,
                         input int hold, input bit pulse);
    logic [31:0] ep;
    logic        eapprox;
    int          en;
    int          lat;
    ref_model(ta, tb_, tm, ep, eapprox, en);
    @(negedge clk);
    a = ta; b = tb_; mode = tm; in_valid = 1'b1;
    check({tag, "_in_ready_idle"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(en + 1));
    check({tag, "_p"}, 64'(p), 64'(ep));
    check({tag, "_approx"}, 64'(approx), 64'(eapprox));
    for (int i = 0; i < hold; i++) begin
      in_valid = pulse;
      if (pulse) begin a = 16'($urandom); b = 16'($urandom); end
      @(posedge clk); #1;
      check({tag, "_hold_p"}, 64'(p), 64'(ep));
      check({tag, "_hold_state"}, 64'({out_valid, in_ready}), 64'(2'b10));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release"}, 64'({out_valid, in_ready}), 64'(2'b01));
    check({tag, "_p_after"}, 64'(p), 64'(ep));
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rm;
    int          path;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({out_valid, approx, in_ready, p}), 64'(0));
    rst_n = 1'b1;

    run_txn("exact_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
    run_txn("small_a",    16'h00FF, 16'h1234, 1'b0, 0, 1'b0);
    run_txn("small_b",    16'h1234, 16'h00FF, 1'b0, 0, 1'b0);
    run_txn("etm_s_lt_t", 16'h1203, 16'h3405, 1'b0, 0, 1'b0);
    run_txn("etm_s_ge_t", 16'h0103, 16'h0103, 1'b0, 0, 1'b0);
    run_txn("etm_lo_zero",16'h1200, 16'h3477, 1'b0, 0, 1'b0);
    run_txn("backpress",  16'hABCD, 16'h1357, 1'b0, 5, 1'b1);

    // Reset during CALC iteration 4
    @(negedge clk);
    a = 16'h9876; b = 16'h5432; mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midop_reset", 64'({out_valid, approx, in_ready, p}), 64'(0));
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      check("midop_no_result", 64'(out_valid), 64'(0));
    end
    run_txn("after_reset", 16'h1203, 16'h3405, 1'b0, 0, 1'b0);

    for (int t = 0; t < 3000; t++) begin
      path = $urandom_range(0, 2);
      ra = 16'($urandom); rb = 16'($urandom);
      rm = (path == 0);
      if (path == 1) begin
        case ($urandom_range(0, 2))
          0: ra[15:8] = 8'h00;
          1: rb[15:8] = 8'h00;
          default: begin ra[15:8] = 8'h00; rb[15:8] = 8'h00; end
        endcase
      end else if (path == 2) begin
        if (ra[15:8] == 8'h00) ra[15:8] = 8'h01;
        if (rb[15:8] == 8'h00) rb[15:8] = 8'h01;
      end
      if ($urandom_range(0, 7) == 0) ra[7:0] = 8'h00;
      run_txn("random", ra, rb, rm, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
